// File: rtl/temp_monitor_if.sv
// rtl/temp_monitor_if.sv - sample/threshold inputs and averaged-result outputs of temp_monitor
interface temp_monitor_if;
  logic        done_i;
  logic [15:0] t_raw;
  logic [15:0] thr_hi;
  logic [15:0] thr_lo;
  logic [15:0] t_avg;
  logic        t_valid;
  logic        alarm;
  logic [7:0]  err_cnt;
  logic        timeout;
  logic [15:0] t_min;
  logic [15:0] t_max;

  modport master (
    output done_i, t_raw, thr_hi, thr_lo,
    input  t_avg, t_valid, alarm, err_cnt, timeout, t_min, t_max
  );

  modport slave (
    input  done_i, t_raw, thr_hi, thr_lo,
    output t_avg, t_valid, alarm, err_cnt, timeout, t_min, t_max
  );
endinterface

// File: rtl/temp_monitor.sv
// rtl/temp_monitor.sv - range check, moving average, hysteretic alarm and sample watchdog
// Optional min/max tracking of accepted samples enabled by TEMP_MON_MINMAX_EN.
module temp_monitor #(
  parameter int FCLK       = 125,
  parameter int AVG_LOG2   = 2,
  parameter int TIMEOUT_MS = 2000,
  parameter int RAW_MIN    = -880,
  parameter int RAW_MAX    = 2000
) (
  input  logic            clk,
  input  logic            rst,
  temp_monitor_if.slave   bus
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW    = 16 + AVG_LOG2;
  localparam logic [31:0]        LIMIT = 32'(FCLK * 1000 * TIMEOUT_MS);
  localparam logic signed [15:0] RMIN  = 16'(RAW_MIN);
  localparam logic signed [15:0] RMAX  = 16'(RAW_MAX);

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, OUT} state_t;

  state_t                state_q, state_d;
  logic                  done_q;
  logic [15:0]           raw_q, raw_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic [15:0]           ring_q [DEPTH];
  logic [15:0]           ring_d [DEPTH];
  logic [PW-1:0]         wp_q, wp_d, wp_nxt;
  logic                  filled_q, filled_d;
  logic [15:0]           t_avg_q, t_avg_d;
  logic                  t_valid_q, t_valid_d;
  logic                  alarm_q, alarm_d;
  logic [7:0]            err_q, err_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  samp_edge;
  logic signed [SW-1:0]  new_ext, old_ext;
  logic signed [15:0]    avg_new;

  assign samp_edge = bus.done_i & ~done_q;
  assign new_ext   = SW'($signed(raw_q));
  assign old_ext   = SW'($signed(ring_q[wp_q]));
  assign avg_new   = 16'(sum_q >>> AVG_LOG2);
  assign wp_nxt    = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    raw_d     = raw_q;
    sum_d     = sum_q;
    ring_d    = ring_q;
    wp_d      = wp_q;
    filled_d  = filled_q;
    t_avg_d   = t_avg_q;
    t_valid_d = 1'b0;
    alarm_d   = alarm_q;
    err_d     = err_q;
    // Any edge, even one ignored by a busy pipeline, proves the reader is alive.
    if (samp_edge)           cnt_d = '0;
    else if (cnt_q == LIMIT) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (samp_edge) begin
          raw_d   = bus.t_raw;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ($signed(raw_q) < RMIN || $signed(raw_q) > RMAX) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // First accepted sample primes the whole ring so the average starts on it.
        if (!filled_q) begin
          for (int i = 0; i < DEPTH; i++) ring_d[i] = raw_q;
          sum_d    = new_ext <<< AVG_LOG2;
          filled_d = 1'b1;
        end else begin
          ring_d[wp_q] = raw_q;
          sum_d        = sum_q + new_ext - old_ext;
        end
        wp_d    = wp_nxt;
        state_d = OUT;
      end
      OUT: begin
        t_avg_d   = avg_new;
        t_valid_d = 1'b1;
        if (avg_new > $signed(bus.thr_hi))      alarm_d = 1'b1;
        else if (avg_new < $signed(bus.thr_lo)) alarm_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b1;
      raw_q     <= '0;
      sum_q     <= '0;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wp_q      <= '0;
      filled_q  <= 1'b0;
      t_avg_q   <= '0;
      t_valid_q <= 1'b0;
      alarm_q   <= 1'b0;
      err_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= bus.done_i;
      raw_q     <= raw_d;
      sum_q     <= sum_d;
      ring_q    <= ring_d;
      wp_q      <= wp_d;
      filled_q  <= filled_d;
      t_avg_q   <= t_avg_d;
      t_valid_q <= t_valid_d;
      alarm_q   <= alarm_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.t_avg   = t_avg_q;
  assign bus.t_valid = t_valid_q;
  assign bus.alarm   = alarm_q;
  assign bus.err_cnt = err_q;
  assign bus.timeout = (cnt_q == LIMIT);

`ifdef TEMP_MON_MINMAX_EN
  logic [15:0] t_min_q, t_min_d;
  logic [15:0] t_max_q, t_max_d;

  always_comb begin
    t_min_d = t_min_q;
    t_max_d = t_max_q;
    if (state_q == ACCUM) begin
      if ($signed(raw_q) < $signed(t_min_q)) t_min_d = raw_q;
      if ($signed(raw_q) > $signed(t_max_q)) t_max_d = raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_min_q <= 16'h7FFF;
      t_max_q <= 16'h8000;
    end else begin
      t_min_q <= t_min_d;
      t_max_q <= t_max_d;
    end
  end

  assign bus.t_min = t_min_q;
  assign bus.t_max = t_max_q;
`else
  assign bus.t_min = 16'h7FFF;
  assign bus.t_max = 16'h8000;
`endif
endmodule

// File: tb/tb_temp_monitor.sv
// tb/tb_temp_monitor.sv - scoreboard bench for temp_monitor (shortened watchdog limit)
module tb_temp_monitor;
  localparam int LIMIT = 10 * 1000 * 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_err = 0;

  typedef struct {
    logic [15:0] avg;
    logic        alarm;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  temp_monitor_if bus();

  temp_monitor #(.FCLK(10), .TIMEOUT_MS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every t_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.t_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_t_valid: got t_avg %0h with no expectation (cycle %0d)", bus.t_avg, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("t_valid_cycle", cyc, e.cyc);
        chk("t_avg", bus.t_avg, e.avg);
        chk("alarm", bus.alarm, e.alarm);
      end
    end
  end

  task automatic send(input logic [15:0] v, input bit acc, input logic [15:0] ea, input logic eal);
    @(posedge clk); #1;
    bus.t_raw  = v;
    bus.done_i = 1'b1;
    if (acc) sb.push_back('{ea, eal, cyc + 4});
    else exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 0;
  endtask

  initial begin
    int t0, t1, n;
    rst        = 1'b1;
    bus.done_i = 1'b1;
    bus.t_raw  = 16'h0191;
    bus.thr_hi = 16'h0320;
    bus.thr_lo = 16'h0300;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    // done_i high out of reset must not look like an edge
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_t_avg", bus.t_avg, 16'h0000);
    chk("rst_t_valid", bus.t_valid, 1'b0);
    chk("rst_alarm", bus.alarm, 1'b0);
    chk("rst_err_cnt", bus.err_cnt, 8'd0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_t_min", bus.t_min, 16'h7FFF);
    chk("rst_t_max", bus.t_max, 16'h8000);
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    repeat (2) @(posedge clk);

    // first sample, then range boundaries
    send(16'h0191, 1, 16'h0191, 1'b0);
    send(16'd2001, 0, 0, 0);
    send(-16'sd881, 0, 0, 0);
    send(16'h07E0, 0, 0, 0);
    @(negedge clk);
    chk("reject_err_cnt", bus.err_cnt, 8'(exp_err));
    chk("reject_t_avg_kept", bus.t_avg, 16'h0191);
    send(16'd2000, 1, 16'd800, 1'b0);
    send(-16'sd880, 1, 16'd480, 1'b0);

    // reset while the sample sits in ACCUM
    @(posedge clk); #1;
    bus.t_raw  = 16'h0100;
    bus.done_i = 1'b1;
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midrst_t_avg", bus.t_avg, 16'h0000);
    chk("midrst_err_cnt", bus.err_cnt, 8'd0);

    // average ramp
    bus.thr_hi = 16'd2000;
    bus.thr_lo = 16'd0;
    send(16'd400, 1, 16'd400, 1'b0);
    send(16'd800, 1, 16'd500, 1'b0);
    send(16'd800, 1, 16'd600, 1'b0);
    send(16'd800, 1, 16'd700, 1'b0);
    send(16'd800, 1, 16'd800, 1'b0);

    // hysteresis
    do_reset();
    bus.thr_hi = 16'd720;
    bus.thr_lo = 16'd640;
    send(16'd700, 1, 16'd700, 1'b0);
    send(16'd820, 1, 16'd730, 1'b1);
    send(16'd580, 1, 16'd700, 1'b1);
    send(16'd420, 1, 16'd630, 1'b0);

    // a second edge during ACCUM is ignored
    @(posedge clk); #1;
    bus.t_raw  = 16'd720;
    bus.done_i = 1'b1;
    sb.push_back('{16'd635, 1'b0, cyc + 4});
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    @(posedge clk); #1;
    bus.t_raw  = 16'd0;
    bus.done_i = 1'b1;
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("busy_edge_err_cnt", bus.err_cnt, 8'd0);

    // error counter saturation
    bus.t_raw = 16'h07E0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      bus.done_i = 1'b1;
      @(posedge clk); #1;
      bus.done_i = 1'b0;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_cnt_sat", bus.err_cnt, 8'd255);
    chk("sat_t_avg_kept", bus.t_avg, 16'd635);

    // negative average floors toward minus infinity
    do_reset();
    send(-16'sd3, 1, 16'hFFFD, 1'b0);
    send(-16'sd4, 1, 16'hFFFC, 1'b0);

    // min/max and watchdog
    do_reset();
    bus.thr_hi = 16'd2000;
    bus.thr_lo = 16'd0;
    send(16'd100, 1, 16'd100, 1'b0);
    send(-16'sd50, 1, 16'd62, 1'b0);
    send(16'd300, 1, 16'd112, 1'b0);
    send(16'd3000, 0, 0, 0);
    @(negedge clk);
`ifdef TEMP_MON_MINMAX_EN
    chk("t_min", bus.t_min, 16'hFFCE);
    chk("t_max", bus.t_max, 16'h012C);
`else
    chk("t_min_tied", bus.t_min, 16'h7FFF);
    chk("t_max_tied", bus.t_max, 16'h8000);
`endif

    @(posedge clk); #1;
    bus.done_i = 1'b1;
    exp_err++;
    t0 = cyc;
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    n = 0;
    while (n < 2 * LIMIT) begin
      @(negedge clk);
      if (bus.timeout === 1'b1) break;
      n++;
    end
    chk("timeout_latency", cyc - t0, LIMIT + 1);
    repeat (5) @(negedge clk);
    chk("timeout_held", bus.timeout, 1'b1);
    chk("timeout_t_avg_kept", bus.t_avg, 16'd112);
    chk("timeout_err_cnt", bus.err_cnt, 8'(exp_err));
    @(posedge clk); #1;
    bus.t_raw  = 16'd100;
    bus.done_i = 1'b1;
    t1 = cyc;
    sb.push_back('{16'd112, 1'b0, t1 + 4});
    @(negedge clk);
    chk("timeout_edge_cycle", bus.timeout, 1'b1);
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    @(negedge clk);
    chk("timeout_cleared", bus.timeout, 1'b0);
    repeat (8) @(posedge clk);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
